// File: rtl/writeback_pipe_buffer.sv
// Execute-to-writeback buffer: two-entry skid FIFO with valid/ready handshake,
// flush, qualified control outputs and a committed condition-flag register.
module writeback_pipe_buffer #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int FLAG_W = 4,
    parameter logic [FLAG_W-1:0] FLAG_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] nwrite_data,
    input  logic [ADDR_W-1:0] nwrite_addr,
    input  logic              nregwrite,
    input  logic              nbranch,
    input  logic              nsetflags,
    input  logic [FLAG_W-1:0] nflags,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] write_data,
    output logic [ADDR_W-1:0] write_addr,
    output logic              regwrite,
    output logic              branch,
    output logic              setflags,
    output logic [FLAG_W-1:0] flags,
    output logic [FLAG_W-1:0] arch_flags,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              regwrite;
        logic              branch;
        logic              setflags;
        logic [FLAG_W-1:0] flags;
    } entry_t;

    entry_t head;
    entry_t skid;
    entry_t incoming;
    logic   head_valid;
    logic   skid_valid;
    logic   accept;
    logic   retire;

    assign incoming = '{
        data:     nwrite_data,
        addr:     nwrite_addr,
        regwrite: nregwrite,
        branch:   nbranch,
        setflags: nsetflags,
        flags:    nflags
    };

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = !skid_valid;
    assign out_valid = head_valid;
    assign accept    = in_valid && in_ready;
    assign retire    = head_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            skid       <= '0;
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            arch_flags <= FLAG_RST;
        end else begin
            if (retire && head.setflags) begin
                arch_flags <= head.flags;
            end
            if (flush) begin
                head_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (retire && !accept) begin
                if (skid_valid) begin
                    head <= skid;
                end
                head_valid <= skid_valid;
                skid_valid <= 1'b0;
            end else if (accept && !retire) begin
                if (!head_valid) begin
                    head       <= incoming;
                    head_valid <= 1'b1;
                end else begin
                    skid       <= incoming;
                    skid_valid <= 1'b1;
                end
            end else if (accept && retire) begin
                if (!skid_valid) begin
                    head <= incoming;
                end else begin
                    head <= skid;
                    skid <= incoming;
                end
                head_valid <= 1'b1;
            end
        end
    end

    assign write_data = head.data;
    assign write_addr = head.addr;
    assign flags      = head.flags;
    assign regwrite   = head.regwrite && head_valid;
    assign branch     = head.branch && head_valid;
    assign setflags   = head.setflags && head_valid;
    assign occupancy  = {1'b0, head_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_writeback_pipe_buffer.sv
// Bench for writeback_pipe_buffer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_writeback_pipe_buffer;

    localparam logic [3:0] FRST = 4'b0110;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] nwrite_data;
    logic [4:0]  nwrite_addr;
    logic        nregwrite;
    logic        nbranch;
    logic        nsetflags;
    logic [3:0]  nflags;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] write_data;
    logic [4:0]  write_addr;
    logic        regwrite;
    logic        branch;
    logic        setflags;
    logic [3:0]  flags;
    logic [3:0]  arch_flags;
    logic [1:0]  occupancy;

    writeback_pipe_buffer #(
        .DATA_W(64), .ADDR_W(5), .FLAG_W(4), .FLAG_RST(FRST)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .nwrite_data(nwrite_data), .nwrite_addr(nwrite_addr),
        .nregwrite(nregwrite), .nbranch(nbranch),
        .nsetflags(nsetflags), .nflags(nflags),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .write_data(write_data), .write_addr(write_addr),
        .regwrite(regwrite), .branch(branch), .setflags(setflags),
        .flags(flags), .arch_flags(arch_flags), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] d;
        logic [4:0]  a;
        logic        rw;
        logic        br;
        logic        sf;
        logic [3:0]  f;
    } ent_t;

    ent_t       q[$];
    logic [3:0] m_arch = FRST;

    // Reference: a FIFO of capacity 2; flush empties it after any retire.
    always @(posedge clk) begin
        bit   acc;
        bit   ret;
        ent_t e;
        if (rst) begin
            q.delete();
            m_arch = FRST;
        end else begin
            acc = in_valid && (q.size() < 2);
            ret = out_ready && (q.size() > 0);
            if (ret) begin
                if (q[0].sf) m_arch = q[0].f;
                void'(q.pop_front());
            end
            if (flush) begin
                q.delete();
            end else if (acc) begin
                e.d  = nwrite_data;
                e.a  = nwrite_addr;
                e.rw = nregwrite;
                e.br = nbranch;
                e.sf = nsetflags;
                e.f  = nflags;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("occupancy", 64'(occupancy), 64'(q.size()));
            chk("arch_flags", 64'(arch_flags), 64'(m_arch));
            if (q.size() > 0) begin
                chk("write_data", write_data, q[0].d);
                chk("write_addr", 64'(write_addr), 64'(q[0].a));
                chk("flags", 64'(flags), 64'(q[0].f));
                chk("regwrite", 64'(regwrite), 64'(q[0].rw));
                chk("branch", 64'(branch), 64'(q[0].br));
                chk("setflags", 64'(setflags), 64'(q[0].sf));
            end else begin
                chk("regwrite_idle", 64'(regwrite), 64'd0);
                chk("branch_idle", 64'(branch), 64'd0);
                chk("setflags_idle", 64'(setflags), 64'd0);
            end
        end
    end

    task automatic step(input bit iv, input logic [63:0] d, input logic [4:0] a,
                        input bit rw, input bit br, input bit sf,
                        input logic [3:0] f, input bit ordy, input bit fl,
                        input bit rs);
        in_valid    = iv;
        nwrite_data = d;
        nwrite_addr = a;
        nregwrite   = rw;
        nbranch     = br;
        nsetflags   = sf;
        nflags      = f;
        out_ready   = ordy;
        flush       = fl;
        rst         = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy);
        step(0, 64'h0, 5'd0, 0, 0, 0, 4'h0, ordy, 0, 0);
    endtask

    initial begin
        step(0, 64'h0, 5'd0, 0, 0, 0, 4'h0, 0, 0, 1);
        chk_en = 1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_data", write_data, 64'd0);
        chk("rst_addr", 64'(write_addr), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_arch", 64'(arch_flags), 64'(FRST));

        // Streaming at full rate
        step(1, 64'h11, 5'd3, 1, 0, 0, 4'h0, 1, 0, 0);
        chk("strA_data", write_data, 64'h11);
        chk("strA_addr", 64'(write_addr), 64'd3);
        chk("strA_rw", 64'(regwrite), 64'd1);
        step(1, 64'h22, 5'd4, 0, 1, 0, 4'h0, 1, 0, 0);
        chk("strB_data", write_data, 64'h22);
        chk("strB_occ", 64'(occupancy), 64'd1);
        chk("strB_rdy", 64'(in_ready), 64'd1);
        step(1, 64'h33, 5'd5, 1, 0, 0, 4'h0, 1, 0, 0);
        chk("strC_data", write_data, 64'h33);
        idle(1);

        // Back-pressure
        step(1, 64'hA, 5'd1, 1, 0, 0, 4'h0, 0, 0, 0);
        chk("bp_occ1", 64'(occupancy), 64'd1);
        step(1, 64'hB, 5'd2, 1, 0, 0, 4'h0, 0, 0, 0);
        chk("bp_occ2", 64'(occupancy), 64'd2);
        chk("bp_rdy0", 64'(in_ready), 64'd0);
        step(1, 64'hC, 5'd6, 1, 0, 0, 4'h0, 0, 0, 0);
        chk("bp_hold", write_data, 64'hA);
        idle(1);
        chk("bp_B", write_data, 64'hB);
        chk("bp_rdy1", 64'(in_ready), 64'd1);
        idle(1);
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Flags commit on retire only
        step(1, 64'h1, 5'd1, 0, 0, 1, 4'b1010, 0, 0, 0);
        chk("fl_noacc", 64'(arch_flags), 64'(FRST));
        step(1, 64'h2, 5'd2, 0, 0, 0, 4'b0101, 1, 0, 0);
        chk("fl_commit", 64'(arch_flags), 64'b1010);
        idle(1);
        chk("fl_hold", 64'(arch_flags), 64'b1010);

        // Flush with two entries and a same-cycle input
        step(1, 64'h5, 5'd7, 1, 1, 0, 4'h0, 0, 0, 0);
        step(1, 64'h6, 5'd8, 1, 1, 0, 4'h0, 0, 0, 0);
        step(1, 64'h7, 5'd9, 1, 1, 1, 4'hF, 0, 1, 0);
        chk("fls_ov", 64'(out_valid), 64'd0);
        chk("fls_occ", 64'(occupancy), 64'd0);
        chk("fls_rw", 64'(regwrite), 64'd0);
        chk("fls_br", 64'(branch), 64'd0);
        chk("fls_rdy", 64'(in_ready), 64'd1);
        chk("fls_arch", 64'(arch_flags), 64'b1010);
        idle(1);
        chk("fls_drop", 64'(out_valid), 64'd0);

        // Flush while a setflags entry retires
        step(1, 64'h8, 5'd1, 1, 0, 1, 4'b0011, 0, 0, 0);
        step(0, 64'h0, 5'd0, 0, 0, 0, 4'h0, 1, 1, 0);
        chk("flsr_arch", 64'(arch_flags), 64'b0011);
        chk("flsr_occ", 64'(occupancy), 64'd0);

        // Reset mid-stream with a pending setflags head
        step(1, 64'h9, 5'd2, 1, 1, 1, 4'b1100, 0, 0, 0);
        step(1, 64'hA, 5'd3, 1, 1, 1, 4'b1001, 0, 0, 0);
        step(1, 64'hB, 5'd4, 1, 1, 1, 4'b1111, 1, 0, 1);
        chk("rs_arch", 64'(arch_flags), 64'(FRST));
        chk("rs_ov", 64'(out_valid), 64'd0);
        chk("rs_rdy", 64'(in_ready), 64'd1);
        chk("rs_data", write_data, 64'd0);
        chk("rs_sf", 64'(setflags), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom, $urandom},
                 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
        end
        idle(1);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_pipe_buffer.md
Name: writeback_pipe_buffer

Overview:
- Parametrised execute→writeback pipeline buffer; next generation of the single-register writeback latch.
- Adds a valid/ready handshake with a 2-entry skid (full throughput under back-pressure), flush of in-flight entries, and qualified control outputs.
- Adds an architectural flags register, updated only when an instruction with setflags retires.
- Sits between the execute/memory stage and the register-file write port / branch unit.

Parameters:
- DATA_W, 64, width of write_data.
- ADDR_W, 5, width of the destination register address.
- FLAG_W, 4, width of the condition-flag vector.
- FLAG_RST, 0, reset value of the arch_flags register (FLAG_W bits).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  buffer can accept this cycle.
- nwrite_data  in  DATA_W  result value.
- nwrite_addr  in  ADDR_W  destination register.
- nregwrite  in  1  entry writes the register file.
- nbranch  in  1  entry is a taken branch.
- nsetflags  in  1  entry updates flags.
- nflags  in  FLAG_W  flag values produced by the entry.
- flush  in  1  discard all buffered entries and this cycle's input.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes head.
- write_data  out  DATA_W  head data.
- write_addr  out  ADDR_W  head destination.
- regwrite, branch, setflags  out  1 each  head control, forced 0 when out_valid=0.
- flags  out  FLAG_W  head flag values.
- arch_flags  out  FLAG_W  committed flag register.
- occupancy  out  2  buffered entries, 0..2.

Behaviour:
- Storage:
  - Two entries: head (drives the outputs) and skid.
  - Each entry holds data, addr, regwrite, branch, setflags and flags, plus a valid bit.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Retire = out_valid & out_ready.
  - in_ready = !skid.valid, a registered value with no combinational path from out_ready.
  - out_valid = head.valid.
- Latency:
  - An entry accepted into an empty buffer appears on the outputs the next cycle.
  - Throughput is 1 entry/cycle while out_ready=1.
- Next-state rules (flush=0):
  - Retire, no accept: head ← skid (if valid), skid.valid←0.
  - Accept, no retire: input goes to head if head is empty, else to skid.
  - Accept and retire: input goes to head if skid is empty; otherwise head ← skid and skid ← input. The latter case cannot occur because in_ready=0 when skid is valid.
  - Neither: hold.
- Ordering: strict FIFO; the skid entry always retires after head.
- Control qualification: regwrite/branch/setflags = stored bit & head.valid. write_data, write_addr and flags hold their last values when invalid; don't-care for checking.
- arch_flags:
  - On a retire with head.setflags=1, arch_flags ← head flags.
  - Otherwise it holds.
  - Updated only on retire, never on accept.
- flush:
  - Next cycle: head.valid=0, skid.valid=0, occupancy=0.
  - A same-cycle input is dropped even though the handshake completed.
  - A same-cycle retire still completes downstream and updates arch_flags; the entry is then removed.
  - in_ready=1 the cycle after a flush.
- occupancy = head.valid + skid.valid.
- Reset (rst=1, overrides flush and all handshakes):
  - Both valid bits 0; out_valid=0; regwrite=branch=setflags=0; occupancy=0; in_ready=1 next cycle.
  - write_data=0, write_addr=0, flags=0.
  - arch_flags=FLAG_RST.
  - Reset mid-stream discards all entries; no arch_flags update occurs in the reset cycle.
- Width rules: all fields are passed through unmodified; no arithmetic except the 2-bit occupancy sum.

Test Plan:
- Reset, then stream A(data=0x11, addr=3, regwrite=1), B, C with out_ready=1 → outputs A, B, C on consecutive cycles, 1 cycle after each accept; occupancy stays 1; in_ready stays 1.
- Back-pressure: out_ready=0, send A then B → occupancy 1 then 2; in_ready=0 after B is accepted; a third input is held off. Raise out_ready → A retires, then B, in order; in_ready returns to 1 the cycle after A retires.
- Flags: retire an entry with setflags=1, flags=4'b1010, then an entry with setflags=0, flags=4'b0101 → arch_flags=1010 after the first retire and stays 1010.
- Flush with occupancy=2 and in_valid=1 → next cycle out_valid=0, occupancy=0, regwrite=0, branch=0; the flushed input never appears; arch_flags unchanged unless a setflags entry retired in the flush cycle.
- Qualification: head holds regwrite=1 with out_ready=0, then flush → regwrite drops to 0 the next cycle, with no spurious write.
- rst asserted with occupancy=2 and a pending setflags entry → next cycle all outputs at reset values, arch_flags=FLAG_RST, in_ready=1.
